uart_cmd_controller: RTL and testbench

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

---
 rtl/uart_cmd_if.sv | 29 ++
 rtl/uart_cmd_controller.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: bundles the byte-receive side and the processor-control side
// of the UART command controller.
//   rx_valid/rx_data/rx_ferr : received byte strobe, data, framing error
//   cpu_rst/cpu_halt/cpu_step : processor control (reset level, halt level,
//                               single-step pulse)
//   led_sel/busy/err_count    : display select, FSM-not-idle, error counter
// The master modport belongs to the byte source / observer; the slave
// modport belongs to the controller.
interface uart_cmd_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;
    logic       cpu_rst;
    logic       cpu_halt;
    logic       cpu_step;
    logic [1:0] led_sel;
    logic       busy;
    logic [7:0] err_count;

    modport master (
        output rx_valid, rx_data, rx_ferr,
        input  cpu_rst, cpu_halt, cpu_step, led_sel, busy, err_count
    );

    modport slave (
        input  rx_valid, rx_data, rx_ferr,
        output cpu_rst, cpu_halt, cpu_step, led_sel, busy, err_count
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: decodes single-byte commands from a UART receiver and
// drives processor debug controls.
//   clk  : system clock (sole clock)
//   rst  : synchronous active-high reset
//   bus  : uart_cmd_if.slave
//          in : rx_valid (1-cycle strobe), rx_data[7:0], rx_ferr
//          out: cpu_rst, cpu_halt, cpu_step (1-cycle pulse), led_sel[1:0],
//               busy, err_count[7:0] (saturating)
// Commands (IDLE): 'r' reset hold, 'h' halt, 'g' go, 'a' toggle halt,
// 's' step (only while halted), 'm' + '0'..'3' select LED source.
// Every output is a flop; a command is visible one cycle after its byte.
module uart_cmd_controller #(
    parameter int RESET_CYCLES   = 100_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input logic        clk,
    input logic        rst,
    uart_cmd_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ARG   = 2'd1,
        RESET_HOLD = 2'd2
    } state_t;

    // One width covers both counters; each counts up to its limit minus one.
    localparam int MAXC = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] hold_cnt, hold_n;
    logic [CW-1:0] tmo_cnt, tmo_n;
    logic          cpu_rst_q, cpu_rst_n;
    logic          halt_q, halt_n;
    logic          step_q, step_n;
    logic [1:0]    led_q, led_n;
    logic          busy_q, busy_n;
    logic [7:0]    err_q, err_n;
    logic          err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
            cpu_rst_q <= 1'b0;
            halt_q    <= 1'b0;
            step_q    <= 1'b0;
            led_q     <= 2'd0;
            busy_q    <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            tmo_cnt   <= tmo_n;
            cpu_rst_q <= cpu_rst_n;
            halt_q    <= halt_n;
            step_q    <= step_n;
            led_q     <= led_n;
            busy_q    <= busy_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        tmo_n     = tmo_cnt;
        cpu_rst_n = cpu_rst_q;
        halt_n    = halt_q;
        step_n    = 1'b0;
        led_n     = led_q;
        err_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_ferr) begin
                        err_inc = 1'b1;
                    end else begin
                        case (bus.rx_data)
                            8'h72: begin
                                cpu_rst_n = 1'b1;
                                hold_n    = '0;
                                state_n   = RESET_HOLD;
                            end
                            8'h68: halt_n = 1'b1;
                            8'h67: halt_n = 1'b0;
                            8'h61: halt_n = ~halt_q;
                            8'h73: step_n = halt_q;  // silently ignored when running
                            8'h6D: begin
                                tmo_n   = '0;
                                state_n = WAIT_ARG;
                            end
                            default: err_inc = 1'b1;
                        endcase
                    end
                end
            end

            WAIT_ARG: begin
                // A byte in the final timeout cycle wins over the timeout.
                if (bus.rx_valid) begin
                    state_n = IDLE;
                    tmo_n   = '0;
                    if (!bus.rx_ferr && bus.rx_data[7:2] == 6'b001100)
                        led_n = bus.rx_data[1:0];
                    else
                        err_inc = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = IDLE;
                    tmo_n   = '0;
                    err_inc = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end

            RESET_HOLD: begin
                // Bytes (including framing errors) are dropped here.
                if (hold_cnt == HOLD_LAST) begin
                    state_n   = IDLE;
                    cpu_rst_n = 1'b0;
                    hold_n    = '0;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase

        err_n  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        busy_n = (state_n != IDLE);
    end

    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.cpu_halt  = halt_q;
    assign bus.cpu_step  = step_q;
    assign bus.led_sel   = led_q;
    assign bus.busy      = busy_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed self-checking bench for uart_cmd_controller with
// RESET_CYCLES=8, TIMEOUT_CYCLES=16. Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_uart_cmd_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   fails = 0;

    uart_cmd_if bus();

    uart_cmd_controller #(
        .RESET_CYCLES  (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a byte for one cycle; on return the command's effect is visible.
    task automatic send(input logic [7:0] b, input logic ferr);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        bus.rx_ferr  = ferr;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs every output: {cpu_rst,cpu_halt,cpu_step,led_sel,busy,err_count}
    function automatic logic [31:0] outs();
        return {18'd0, bus.cpu_rst, bus.cpu_halt, bus.cpu_step, bus.led_sel,
                bus.busy, bus.err_count};
    endfunction

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_ferr  = 1'b0;

        // Reset state
        rst = 1'b1;
        ticks(3);
        chk("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        tick();

        // 'r' at cycle T: cpu_rst/busy high T+1..T+8, low at T+9
        send(8'h72, 1'b0);                       // now T+1
        chk("rhold_t1_rst", {31'd0, bus.cpu_rst}, 32'd1);
        chk("rhold_t1_busy", {31'd0, bus.busy}, 32'd1);
        ticks(2);                                // T+3
        send(8'h72, 1'b0);                       // dropped, now T+4
        chk("rhold_t4_rst", {31'd0, bus.cpu_rst}, 32'd1);
        ticks(4);                                // T+8
        chk("rhold_t8_rst", {31'd0, bus.cpu_rst}, 32'd1);
        chk("rhold_t8_busy", {31'd0, bus.busy}, 32'd1);
        tick();                                  // T+9
        chk("rhold_t9_rst", {31'd0, bus.cpu_rst}, 32'd0);
        chk("rhold_t9_busy", {31'd0, bus.busy}, 32'd0);
        chk("rhold_err", {24'd0, bus.err_count}, 32'd0);

        // Halt / step / toggle
        send(8'h73, 1'b0);
        chk("step_running", {31'd0, bus.cpu_step}, 32'd0);
        send(8'h68, 1'b0);
        chk("halt_set", {31'd0, bus.cpu_halt}, 32'd1);
        chk("halt_nostep", {31'd0, bus.cpu_step}, 32'd0);
        send(8'h73, 1'b0);
        chk("step_pulse", {31'd0, bus.cpu_step}, 32'd1);
        tick();
        chk("step_end", {31'd0, bus.cpu_step}, 32'd0);
        bus.rx_valid = 1'b1;                     // back-to-back 's'
        bus.rx_data  = 8'h73;
        tick();
        chk("step_b2b_1", {31'd0, bus.cpu_step}, 32'd1);
        tick();
        bus.rx_valid = 1'b0;
        chk("step_b2b_2", {31'd0, bus.cpu_step}, 32'd1);
        tick();
        chk("step_b2b_end", {31'd0, bus.cpu_step}, 32'd0);
        send(8'h61, 1'b0);
        chk("toggle_off", {31'd0, bus.cpu_halt}, 32'd0);
        send(8'h61, 1'b0);
        chk("toggle_on", {31'd0, bus.cpu_halt}, 32'd1);
        send(8'h67, 1'b0);
        chk("go", {31'd0, bus.cpu_halt}, 32'd0);
        chk("err_after_cmds", {24'd0, bus.err_count}, 32'd0);

        // LED select
        send(8'h6D, 1'b0);
        chk("m_busy", {31'd0, bus.busy}, 32'd1);
        send(8'h32, 1'b0);
        chk("led_2", {30'd0, bus.led_sel}, 32'd2);
        chk("led_2_idle", {31'd0, bus.busy}, 32'd0);
        send(8'h6D, 1'b0);
        send(8'h39, 1'b0);
        chk("led_bad_keep", {30'd0, bus.led_sel}, 32'd2);
        chk("led_bad_err", {24'd0, bus.err_count}, 32'd1);
        chk("led_bad_idle", {31'd0, bus.busy}, 32'd0);

        // Timeout: 'm' at T, WAIT_ARG spans T+1..T+16
        send(8'h6D, 1'b0);                       // T+1
        ticks(15);                               // T+16
        chk("tmo_last_busy", {31'd0, bus.busy}, 32'd1);
        chk("tmo_last_err", {24'd0, bus.err_count}, 32'd1);
        tick();                                  // T+17
        chk("tmo_busy", {31'd0, bus.busy}, 32'd0);
        chk("tmo_err", {24'd0, bus.err_count}, 32'd2);

        // Byte in the last WAIT_ARG cycle is accepted
        send(8'h6D, 1'b0);                       // T+1
        ticks(15);                               // T+16
        send(8'h31, 1'b0);                       // T+17
        chk("late_led", {30'd0, bus.led_sel}, 32'd1);
        chk("late_busy", {31'd0, bus.busy}, 32'd0);
        ticks(3);
        chk("late_err", {24'd0, bus.err_count}, 32'd2);

        // Framing errors
        send(8'h68, 1'b1);
        chk("ferr_halt", {31'd0, bus.cpu_halt}, 32'd0);
        chk("ferr_err", {24'd0, bus.err_count}, 32'd3);
        send(8'h6D, 1'b0);
        send(8'h33, 1'b1);
        chk("ferr_wait_idle", {31'd0, bus.busy}, 32'd0);
        chk("ferr_wait_led", {30'd0, bus.led_sel}, 32'd1);
        chk("ferr_wait_err", {24'd0, bus.err_count}, 32'd4);

        // Unknown bytes and saturation
        send(8'h00, 1'b0);
        chk("unknown_err", {24'd0, bus.err_count}, 32'd5);
        for (int i = 0; i < 249; i++) send(8'h7A, 1'b0);
        chk("err_254", {24'd0, bus.err_count}, 32'd254);
        send(8'h7A, 1'b0);
        chk("err_255", {24'd0, bus.err_count}, 32'd255);
        for (int i = 0; i < 50; i++) send(8'h7A, 1'b0);
        chk("err_sat", {24'd0, bus.err_count}, 32'd255);

        // Reset in cycle 4 of RESET_HOLD
        send(8'h68, 1'b0);
        send(8'h72, 1'b0);                       // hold cycle 1
        ticks(3);                                // hold cycle 4
        chk("pre_abort_rst", {31'd0, bus.cpu_rst}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_outs", outs(), 32'd0);
        bus.rx_valid = 1'b1;                     // ignored during reset
        bus.rx_data  = 8'h68;
        tick();
        bus.rx_valid = 1'b0;
        chk("rst_ignores_rx", outs(), 32'd0);
        rst = 1'b0;
        tick();

        // Reset aborts WAIT_ARG, and the timeout restarts on next entry
        send(8'h6D, 1'b0);
        chk("wait_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wait_abort", outs(), 32'd0);
        send(8'h6D, 1'b0);
        ticks(15);
        chk("tmo2_still_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("tmo2_err", {24'd0, bus.err_count}, 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
